// File: rtl/multicycle_alu_ctrl_if.sv
// Request/response bundle for multicycle_alu_ctrl.
//
// Handshake semantics (both channels):
//   A request transfers on a rising clock edge where valid_i && ready_o.
//   A result transfers on a rising clock edge where valid_o && ready_i.
//   While valid_o is high and ready_i is low, result_o/zero_o/illegal_o hold
//   steady. valid_i seen while ready_o is low has no effect.
//
// Signals:
//   valid_i, funct_i[9:0], ALUOp_i[1:0], rs1_i, rs2_i : request (master -> slave)
//   ready_o                                           : slave can accept
//   valid_o, result_o, zero_o, illegal_o              : response (slave -> master)
//   ready_i                                           : master takes the response
//   state_dbg[1:0]                                    : controller FSM state, debug only
interface multicycle_alu_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            valid_i;
  logic            ready_o;
  logic [9:0]      funct_i;
  logic [1:0]      ALUOp_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            zero_o;
  logic            illegal_o;
  logic [1:0]      state_dbg;

  modport master (
    output valid_i, funct_i, ALUOp_i, rs1_i, rs2_i, ready_i,
    input  ready_o, valid_o, result_o, zero_o, illegal_o, state_dbg
  );

  modport slave (
    input  valid_i, funct_i, ALUOp_i, rs1_i, rs2_i, ready_i,
    output ready_o, valid_o, result_o, zero_o, illegal_o, state_dbg
  );
endinterface

// File: rtl/multicycle_alu_ctrl.sv
// Multicycle ALU controller: decodes ALUOp/funct, computes single-cycle ALU
// operations in one cycle and multiplication with a radix-2 shift-add
// sequencer (one multiplier bit per cycle, XLEN cycles).
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   bus      : multicycle_alu_ctrl_if slave modport (request/response handshake)
//
// FSM: IDLE (ready_o=1) -> DONE for single-cycle ops and illegal requests,
//      IDLE -> MUL -> DONE for multiply; DONE -> IDLE once ready_i is seen.
module multicycle_alu_ctrl #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  multicycle_alu_ctrl_if.slave bus
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_MUL, OP_ILL
  } op_e;

  state_e          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b;
  logic [SHW-1:0]  shamt;
  op_e             op;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] partial;

  assign funct7 = bus.funct_i[9:3];
  assign funct3 = bus.funct_i[2:0];
  assign op_a   = bus.rs1_i;
  assign op_b   = bus.rs2_i;
  assign shamt  = bus.rs2_i[SHW-1:0];

  // Decode. Only meaningful on the accept edge; outside IDLE it is ignored.
  always_comb begin
    op = OP_ILL;
    case (bus.ALUOp_i)
      2'b00: begin
        // I-type: funct7 only qualifies the shift encodings.
        case (funct3)
          3'b000: op = OP_ADD;
          3'b111: op = OP_AND;
          3'b110: op = OP_OR;
          3'b100: op = OP_XOR;
          3'b001: op = (funct7 == 7'b0000000) ? OP_SLL : OP_ILL;
          3'b101: begin
            if (funct7 == 7'b0000000)      op = OP_SRL;
            else if (funct7 == 7'b0100000) op = OP_SRA;
            else                           op = OP_ILL;
          end
          default: op = OP_ILL;
        endcase
      end
      2'b01: op = OP_SUB;
      2'b10: begin
        case ({funct7, funct3})
          10'b0000000_000: op = OP_ADD;
          10'b0000000_111: op = OP_AND;
          10'b0000000_110: op = OP_OR;
          10'b0000000_100: op = OP_XOR;
          10'b0000000_001: op = OP_SLL;
          10'b0000000_101: op = OP_SRL;
          10'b0000000_010: op = OP_SLT;
          10'b0100000_000: op = OP_SUB;
          10'b0100000_101: op = OP_SRA;
          10'b0000001_000: op = MUL_EN ? OP_MUL : OP_ILL;
          default:         op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  // Single-cycle datapath; illegal and mul yield 0 here (mul result comes
  // from the shift-add accumulator instead).
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add the (already shifted) multiplicand when the
  // current low multiplier bit is set.
  assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        // ready_o is high in IDLE, so valid_i alone means accept.
        if (bus.valid_i) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
          end else begin
            state_d   = S_DONE;
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = (op == OP_ILL);
          end
        end
      end
      S_MUL: begin
        acc_d    = partial;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          cnt_d     = '0;
          result_d  = partial;
          zero_d    = (partial == '0);
          illegal_d = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.ready_o   = (state_q == S_IDLE);
  assign bus.valid_o   = (state_q == S_DONE);
  assign bus.result_o  = result_q;
  assign bus.zero_o    = zero_q;
  assign bus.illegal_o = illegal_q;
  assign bus.state_dbg = state_q;

endmodule

// File: doc/multicycle_alu_ctrl.md
MULTICYCLE_ALU_CTRL -- requirements
Module: multicycle_alu_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; legal values are 8, 16, 32, 64.
REQ-002 The block SHALL have parameter MUL_EN, default 1; when 0, mul SHALL decode as illegal.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 valid_i  input  1  request present.
REQ-006 ready_o  output  1  block can accept a request.
REQ-007 funct_i  input  10  [9:3] funct7, [2:0] funct3.
REQ-008 ALUOp_i  input  2  00 I-type, 01 branch compare, 10 R-type, 11 reserved.
REQ-009 rs1_i  input  XLEN  operand A.
REQ-010 rs2_i  input  XLEN  operand B (register or sign-extended immediate).
REQ-011 valid_o  output  1  result present.
REQ-012 ready_i  input  1  consumer takes the result.
REQ-013 result_o  output  XLEN  registered result.
REQ-014 zero_o  output  1  result_o == 0.
REQ-015 illegal_o  output  1  request was undecodable; valid with valid_o.

Function
REQ-016 A request SHALL be accepted only on a cycle with valid_i && ready_o; funct_i, ALUOp_i, rs1_i and rs2_i SHALL be captured on that edge and ignored at all other times.
REQ-017 The FSM SHALL have states IDLE, MUL, DONE; ready_o SHALL be 1 only in IDLE, and valid_o SHALL be 1 only in DONE.
REQ-018 IDLE: accepting a non-mul request SHALL go to DONE with the result registered (latency 1 cycle); accepting mul SHALL go to MUL; no request SHALL stay in IDLE.
REQ-019 ALUOp 00: funct3 000 add, 111 and, 110 or, 100 xor, 001 sll, 101 with funct7 0000000 srl, 101 with funct7 0100000 sra; funct7 SHALL be ignored for non-shift funct3; any other case illegal.
REQ-020 ALUOp 10, funct7 0000000: funct3 000 add, 111 and, 110 or, 100 xor, 001 sll, 101 srl, 010 slt (signed, result 1 or 0).
REQ-021 ALUOp 10, funct7 0100000: funct3 000 sub, 101 sra; funct7 0000001, funct3 000: mul (low XLEN bits of product); any other ALUOp 10 combination illegal.
REQ-022 ALUOp 01 SHALL compute rs1 - rs2 (branch compare); ALUOp 11 SHALL be illegal.
REQ-023 Shift amount SHALL be rs2[log2(XLEN)-1:0]; all add/sub/mul arithmetic SHALL wrap modulo 2^XLEN with no overflow flag.
REQ-024 Illegal requests SHALL complete in 1 cycle via DONE with result_o = 0, zero_o = 1, illegal_o = 1.
REQ-025 MUL SHALL perform radix-2 shift-add, one multiplier bit per cycle, for exactly XLEN cycles under an internal counter 0..XLEN-1, then go to DONE; total latency from accept to valid_o SHALL be XLEN+1 cycles.
REQ-026 DONE: result_o, zero_o, illegal_o SHALL be held stable while valid_o=1 and ready_i=0; on ready_i=1 the FSM SHALL return to IDLE the next cycle (no same-cycle accept; minimum throughput 1 request per 2 cycles).
REQ-027 result_o SHALL keep its last value in IDLE; valid_i asserted while ready_o=0 SHALL have no effect.

Reset
REQ-028 rst_n_i low SHALL immediately force state IDLE, MUL counter 0, valid_o 0, result_o 0, zero_o 1, illegal_o 0; ready_o SHALL be 1 while in reset-IDLE.
REQ-029 Reset asserted during MUL or DONE SHALL abort the operation with no result delivered; the first accept after rst_n_i rises SHALL behave as from power-up.

Verification
REQ-030 XLEN=32, ALUOp 10, funct 0000000_000, rs1=0xFFFFFFFF, rs2=1, ready_i=1 -> valid_o 1 cycle after accept, result_o 0, zero_o 1, illegal_o 0.
REQ-031 ALUOp 00, funct 0100000_101, rs1=0x80000000, rs2=4 -> result_o 0xF8000000; same with funct 0000000_101 -> 0x08000000.
REQ-032 ALUOp 10, funct 0000001_000, rs1=0xFFFFFFFF, rs2=3 -> valid_o exactly 33 cycles after accept, result_o 0xFFFFFFFD; ready_o 0 throughout.
REQ-033 ALUOp 10, funct 0000000_011 -> illegal_o 1, result_o 0, 1-cycle latency; repeat with MUL_EN=0 and mul funct -> illegal_o 1.
REQ-034 Hold ready_i=0 for 5 cycles in DONE while toggling valid_i and operands -> result_o stable, ready_o 0, no new accept; ready_i=1 -> IDLE next cycle.
REQ-035 Assert rst_n_i low at MUL cycle 10, release, issue add 2+3 -> no stale valid_o, result_o 5 after 1 cycle.
